// File: rtl/simple_fifo_adapter.sv
// simple_fifo_adapter
// Single-clock FIFO that packs narrow write words into wide read words.
// Narrow words are collected little-end-first in a packer register. When the
// last slot arrives, the complete wide word goes straight into a
// 2**ADDR_WIDTH-entry memory. The read side only ever sees complete words.
// rd_dat is registered and appears one cycle after the read is accepted.
// DATA_OUT_WIDTH must be an integer multiple of DATA_IN_WIDTH.

module simple_fifo_adapter #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 128,
  parameter int ADDR_WIDTH     = 4,
  parameter int FULL_SLACK     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_ena,
  input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
  output logic                      wr_full,
  input  logic                      rd_ena,
  output logic [DATA_OUT_WIDTH-1:0] rd_dat,
  output logic                      rd_empty,
  output logic [ADDR_WIDTH:0]       rd_dat_cnt
);

  localparam int RATIO = DATA_OUT_WIDTH / DATA_IN_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - FULL_SLACK);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(RATIO - 1);

  // Wide word storage; deliberately not reset so it can map onto RAM
  logic [DATA_OUT_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]     wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0]     rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]       count_q, count_d;
  logic [IDX_W-1:0]          packIdx_q, packIdx_d;
  logic [DATA_OUT_WIDTH-1:0] packReg_q, packReg_d;
  logic [DATA_OUT_WIDTH-1:0] rdData_q, rdData_d;

  logic                      wrAccept;
  logic                      rdAccept;
  logic                      wordDone;
  logic [DATA_OUT_WIDTH-1:0] fullWord;

  // Handshake decisions are based on the registered count only; wr_full is advisory
  always_comb begin
    wrAccept = wr_ena && (count_q < DEPTH_CNT);
    rdAccept = rd_ena && (count_q != '0);
    wordDone = wrAccept && (packIdx_q == LAST_IDX);
  end

  // Completed word = already packed slots plus the word arriving this cycle in the top slot
  always_comb begin
    fullWord = packReg_q;
    fullWord[(RATIO-1)*DATA_IN_WIDTH +: DATA_IN_WIDTH] = wr_dat;
  end

  // Packer next state: drop the word into its slot, or restart after a completed word
  always_comb begin
    packReg_d = packReg_q;
    packIdx_d = packIdx_q;
    if (wordDone) begin
      packReg_d = '0;
      packIdx_d = '0;
    end else if (wrAccept) begin
      for (int k = 0; k < RATIO; k++) begin
        if (packIdx_q == IDX_W'(k)) begin
          packReg_d[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] = wr_dat;
        end
      end
      packIdx_d = packIdx_q + 1'b1;
    end
  end

  // Pointer, occupancy and read-data next state
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    rdData_d = rdData_q;
    if (wordDone) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdAccept) begin
      rdPtr_d  = rdPtr_q + 1'b1;
      rdData_d = mem_q[rdPtr_q];
    end
    case ({wordDone, rdAccept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards stored and partial data at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      packIdx_q <= '0;
      packReg_q <= '0;
      rdData_q  <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      packIdx_q <= packIdx_d;
      packReg_q <= packReg_d;
      rdData_q  <= rdData_d;
    end
  end

  // Memory write of a completed word. A write can never target the slot being
  // read, because a completion needs count < DEPTH.
  always_ff @(posedge clk) begin
    if (wordDone) begin
      mem_q[wrPtr_q] <= fullWord;
    end
  end

  assign rd_dat     = rdData_q;
  assign rd_dat_cnt = count_q;
  assign rd_empty   = (count_q == '0);
  assign wr_full    = (count_q >= FULL_LEVEL);

endmodule

// File: tb/tb_simple_fifo_adapter.sv
// tb_simple_fifo_adapter
// Randomised and directed scenarios for simple_fifo_adapter.
// The expected results come from a queue model kept in this bench.
// The model holds a queue of 16-bit words for the partial wide word
// and a queue of complete 128-bit words.

module tb_simple_fifo_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_ena;
  logic [15:0]  wr_dat;
  logic         wr_full;
  logic         rd_ena;
  logic [127:0] rd_dat;
  logic         rd_empty;
  logic [4:0]   rd_dat_cnt;

  int checks = 0;
  int errors = 0;

  logic [127:0] mWords[$];
  logic [15:0]  mPart[$];
  logic [127:0] mRd;

  simple_fifo_adapter #(
    .DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(128), .ADDR_WIDTH(4), .FULL_SLACK(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_full(wr_full),
    .rd_ena(rd_ena), .rd_dat(rd_dat), .rd_empty(rd_empty), .rd_dat_cnt(rd_dat_cnt)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Behavioural model: the read uses the occupancy before the edge, then an accepted write is packed
  task automatic modelStep(input logic we, input logic [15:0] wd, input logic re);
    int n;
    logic [127:0] w;
    n = mWords.size();
    if (re && n > 0) mRd = mWords.pop_front();
    if (we && n < 16) begin
      mPart.push_back(wd);
      if (mPart.size() == 8) begin
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = mPart[k];
        mWords.push_back(w);
        mPart.delete();
      end
    end
  endtask

  task automatic modelReset();
    mWords.delete();
    mPart.delete();
    mRd = '0;
  endtask

  // One clock: drive the inputs, step the model at the edge, and return 1 ns after the edge
  task automatic tick(input logic we, input logic [15:0] wd, input logic re);
    wr_ena = we;
    wr_dat = wd;
    rd_ena = re;
    @(posedge clk);
    modelStep(we, wd, re);
    #1;
    wr_ena = 1'b0;
    rd_ena = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_ena = 1'b0; rd_ena = 1'b0; wr_dat = '0;
    modelReset();
    #2;
    checks++; if (rd_dat !== 128'h0) begin errors++; $display("[TB] FAIL reset_rd_dat: got %h want 0", rd_dat); end
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", rd_dat_cnt); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b want 1", rd_empty); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b want 0", wr_full); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [127:0] exp;
    for (int i = 0; i < 128; i++) tick(1'b1, 16'(i), 1'b0);
    checks++; if (rd_dat_cnt !== 5'd16) begin errors++; $display("[TB] FAIL fill_cnt: got %0d want 16", rd_dat_cnt); end
    checks++; if (wr_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b want 1", wr_full); end
    checks++; if (rd_empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty: got %b want 0", rd_empty); end
    for (int j = 0; j < 16; j++) begin
      tick(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 8; i++) exp[i*16 +: 16] = 16'(8*j + i);
      checks++; if (rd_dat !== exp) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %h want %h", j, rd_dat, exp); end
    end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b want 1", rd_empty); end
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("[TB] FAIL drain_cnt: got %0d want 0", rd_dat_cnt); end
  endtask

  task automatic test_partial();
    logic [15:0]  bytes [16];
    logic [127:0] exp;
    for (int i = 0; i < 16; i++) begin
      bytes[i] = 16'($urandom_range(0, 255));
      tick(1'b1, bytes[i], 1'b0);
    end
    checks++; if (rd_dat_cnt !== 5'd2) begin errors++; $display("[TB] FAIL partial_cnt: got %0d want 2", rd_dat_cnt); end
    for (int j = 0; j < 2; j++) begin
      tick(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 8; i++) exp[i*16 +: 16] = bytes[8*j + i];
      checks++; if (rd_dat !== exp) begin errors++; $display("[TB] FAIL partial_data[%0d]: got %h want %h", j, rd_dat, exp); end
    end
    tick(1'b0, 16'h0, 1'b1);
    checks++; if (rd_dat !== exp) begin errors++; $display("[TB] FAIL partial_hold: got %h want %h", rd_dat, exp); end
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("[TB] FAIL partial_underflow_cnt: got %0d want 0", rd_dat_cnt); end
  endtask

  task automatic test_overflow();
    logic [15:0]  pushed [136];
    logic [127:0] exp;
    for (int i = 0; i < 136; i++) begin
      pushed[i] = 16'($urandom);
      tick(1'b1, pushed[i], 1'b0);
    end
    checks++; if (rd_dat_cnt !== 5'd16) begin errors++; $display("[TB] FAIL overflow_cnt: got %0d want 16", rd_dat_cnt); end
    // Pop at full with a write in the same edge: the write must be dropped
    tick(1'b1, 16'hAAAA, 1'b1);
    for (int i = 0; i < 8; i++) exp[i*16 +: 16] = pushed[i];
    checks++; if (rd_dat !== exp) begin errors++; $display("[TB] FAIL overflow_first: got %h want %h", rd_dat, exp); end
    checks++; if (rd_dat_cnt !== 5'd15) begin errors++; $display("[TB] FAIL full_rw_cnt: got %0d want 15", rd_dat_cnt); end
    for (int j = 1; j < 16; j++) begin
      tick(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 8; i++) exp[i*16 +: 16] = pushed[8*j + i];
      checks++; if (rd_dat !== exp) begin errors++; $display("[TB] FAIL overflow_data[%0d]: got %h want %h", j, rd_dat, exp); end
    end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL overflow_empty: got %b want 1", rd_empty); end
  endtask

  task automatic test_early_full();
    for (int i = 0; i < 8*14; i++) tick(1'b1, 16'($urandom), 1'b0);
    checks++; if (wr_full !== 1'b0) begin errors++; $display("[TB] FAIL early_full_14: got %b want 0", wr_full); end
    for (int i = 0; i < 7; i++) tick(1'b1, 16'($urandom), 1'b0);
    checks++; if (wr_full !== 1'b0) begin errors++; $display("[TB] FAIL early_full_partial: got %b want 0", wr_full); end
    tick(1'b1, 16'($urandom), 1'b0);
    checks++; if (wr_full !== 1'b1) begin errors++; $display("[TB] FAIL early_full_15: got %b want 1", wr_full); end
    checks++; if (rd_dat_cnt !== 5'd15) begin errors++; $display("[TB] FAIL early_full_cnt: got %0d want 15", rd_dat_cnt); end
    tick(1'b0, 16'h0, 1'b1);
    checks++; if (wr_full !== 1'b0) begin errors++; $display("[TB] FAIL early_full_fall: got %b want 0", wr_full); end
    checks++; if (rd_dat !== mRd) begin errors++; $display("[TB] FAIL early_full_data: got %h want %h", rd_dat, mRd); end
    for (int i = 0; i < 14; i++) tick(1'b0, 16'h0, 1'b1);
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL early_full_drain: got %b want 1", rd_empty); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 32; i++) tick(1'b1, 16'h0009, 1'b0);
    checks++; if (rd_dat_cnt !== 5'd4) begin errors++; $display("[TB] FAIL stream_cnt: got %0d want 4", rd_dat_cnt); end
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 16'h0009, 1'b1);
      checks++; if (rd_dat !== {8{16'h0009}}) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h", i, rd_dat); end
      checks++; if (int'(rd_dat_cnt) != mWords.size()) begin errors++; $display("[TB] FAIL stream_cnt[%0d]: got %0d want %0d", i, rd_dat_cnt, mWords.size()); end
    end
  endtask

  task automatic test_random();
    logic we, re;
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 5) < ((i / 100) % 2 == 0 ? 1 : 5));
      tick(we, 16'($urandom), re);
      checks++; if (rd_dat !== mRd) begin errors++; $display("[TB] FAIL random_data[%0d]: got %h want %h", i, rd_dat, mRd); end
      checks++; if (int'(rd_dat_cnt) != mWords.size()) begin errors++; $display("[TB] FAIL random_cnt[%0d]: got %0d want %0d", i, rd_dat_cnt, mWords.size()); end
      checks++; if (rd_empty !== (mWords.size() == 0)) begin errors++; $display("[TB] FAIL random_empty[%0d]: got %b", i, rd_empty); end
      checks++; if (wr_full !== (mWords.size() >= 15)) begin errors++; $display("[TB] FAIL random_full[%0d]: got %b cnt %0d", i, wr_full, mWords.size()); end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0]  fresh [8];
    logic [127:0] exp;
    for (int i = 0; i < 19; i++) tick(1'b1, 16'($urandom) | 16'h1, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    checks++; if (rd_dat !== mRd) begin errors++; $display("[TB] FAIL pre_reset_data: got %h want %h", rd_dat, mRd); end
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checks++; if (rd_dat !== 128'h0) begin errors++; $display("[TB] FAIL async_rd_dat: got %h want 0", rd_dat); end
    checks++; if (rd_dat_cnt !== 5'd0) begin errors++; $display("[TB] FAIL async_cnt: got %0d want 0", rd_dat_cnt); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL async_empty: got %b want 1", rd_empty); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fresh[i] = 16'($urandom);
      tick(1'b1, fresh[i], 1'b0);
    end
    checks++; if (rd_dat_cnt !== 5'd1) begin errors++; $display("[TB] FAIL post_reset_cnt: got %0d want 1", rd_dat_cnt); end
    tick(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) exp[i*16 +: 16] = fresh[i];
    checks++; if (rd_dat !== exp) begin errors++; $display("[TB] FAIL post_reset_data: got %h want %h", rd_dat, exp); end
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    test_reset();
    test_fill_drain();
    test_partial();
    test_overflow();
    test_early_full();
    test_streaming();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
